// File: rtl/ntt_butterfly_scheduler_if.sv
// rtl/ntt_butterfly_scheduler_if.sv - control and memory-address bundle of the NTT butterfly scheduler
// iSTALL exists only when NTT_SCHED_STALL_EN is defined.
interface ntt_butterfly_scheduler_if #(
  parameter int LOGN = 8
);
`ifdef NTT_SCHED_STALL_EN
  logic            iSTALL;
`endif
  logic            iSTART;
  logic [1:0]      iMODE;
  logic            oBUSY;
  logic            oDONE;
  logic            oRD_EN;
  logic [LOGN-1:0] oRD_ADDR_A;
  logic [LOGN-1:0] oRD_ADDR_B;
  logic [LOGN-1:0] oTW_ADDR;
  logic            oBUF_SEL;
  logic            oBUF_START;
  logic            oWR_EN;
  logic [LOGN-1:0] oWR_ADDR_A;
  logic [LOGN-1:0] oWR_ADDR_B;

  modport master (
`ifdef NTT_SCHED_STALL_EN
    output iSTALL,
`endif
    output iSTART, iMODE,
    input  oBUSY, oDONE, oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR,
    input  oBUF_SEL, oBUF_START, oWR_EN, oWR_ADDR_A, oWR_ADDR_B
  );

  modport slave (
`ifdef NTT_SCHED_STALL_EN
    input  iSTALL,
`endif
    input  iSTART, iMODE,
    output oBUSY, oDONE, oRD_EN, oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR,
    output oBUF_SEL, oBUF_START, oWR_EN, oWR_ADDR_A, oWR_ADDR_B
  );
endinterface

// File: rtl/ntt_butterfly_scheduler.sv
// rtl/ntt_butterfly_scheduler.sv - CT/GS/PWM butterfly address scheduler with LAT-deep write-back pipe
// Optional iSTALL input is enabled by defining NTT_SCHED_STALL_EN.
module ntt_butterfly_scheduler #(
  parameter int LOGN = 8,
  parameter int LAT  = 5
) (
  input  logic                     iSYS_CLK,
  input  logic                     iSYS_RST,
  ntt_butterfly_scheduler_if.slave bus
);
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [1:0] MODE_CT  = 2'b00;
  localparam logic [1:0] MODE_GS  = 2'b01;
  localparam logic [1:0] MODE_PWM = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] k_q, k_d;
  logic [SW-1:0]   s_q, s_d;
  logic [1:0]      mode_q, mode_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            rd_en;
  logic            stall;
  logic            k_last;

  logic [LAT-1:0]  wv_q;
  logic [LOGN-1:0] wa_q [LAT];
  logic [LOGN-1:0] wb_q [LAT];

  logic [SW-1:0]   q, p;
  logic [LOGN-1:0] len, g, j, addr_a, addr_b, addr_tw;

`ifdef NTT_SCHED_STALL_EN
  assign stall = bus.iSTALL;
`else
  assign stall = 1'b0;
`endif

  assign k_last = (mode_q == MODE_PWM) ? (k_q == {LOGN{1'b1}})
                                       : (k_q == LOGN'((1 << (LOGN - 1)) - 1));

  // Pair index k splits at bit p into group g and offset j; A is k with a 0 inserted at bit p.
  always_comb begin
    q       = SW'(LOGN - 1) - s_q;
    p       = (mode_q == MODE_CT) ? q : s_q;
    len     = LOGN'(1) << p;
    g       = k_q >> p;
    j       = k_q & (len - LOGN'(1));
    addr_a  = ((g << p) << 1) | j;
    addr_b  = addr_a | len;
    addr_tw = (mode_q == MODE_CT) ? ((LOGN'(1) << s_q) + g) : ((LOGN'(1) << q) + g);
    if (mode_q == MODE_PWM) begin
      addr_a  = k_q;
      addr_b  = k_q;
      addr_tw = k_q;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    mode_d  = mode_q;
    dcnt_d  = dcnt_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iSTART && bus.iMODE != 2'b11) begin
          state_d = ISSUE;
          mode_d  = bus.iMODE;
          k_d     = '0;
          s_d     = '0;
        end
      end
      ISSUE: begin
        if (!stall) begin
          rd_en = 1'b1;
          if (k_last) begin
            k_d     = '0;
            dcnt_d  = '0;
            state_d = DRAIN;
          end else begin
            k_d = k_q + LOGN'(1);
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(LAT - 1)) begin
          if (mode_q == MODE_PWM || s_q == SW'(LOGN - 1)) begin
            state_d = DONE;
          end else begin
            s_d     = s_q + SW'(1);
            state_d = ISSUE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
    if (iSYS_RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      mode_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Write-back pipe: an entry loaded by a read emerges exactly LAT cycles later.
  always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
    if (iSYS_RST) begin
      wv_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        wa_q[i] <= '0;
        wb_q[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        wv_q[i] <= wv_q[i-1];
        wa_q[i] <= wa_q[i-1];
        wb_q[i] <= wb_q[i-1];
      end
      wv_q[0] <= rd_en;
      wa_q[0] <= rd_en ? addr_a : '0;
      wb_q[0] <= rd_en ? addr_b : '0;
    end
  end

  assign bus.oBUSY      = (state_q != IDLE);
  assign bus.oBUF_START = (state_q != IDLE);
  assign bus.oDONE      = (state_q == DONE);
  assign bus.oBUF_SEL   = (state_q != IDLE) && (mode_q == MODE_GS);
  assign bus.oRD_EN     = rd_en;
  assign bus.oRD_ADDR_A = rd_en ? addr_a : '0;
  assign bus.oRD_ADDR_B = rd_en ? addr_b : '0;
  assign bus.oTW_ADDR   = rd_en ? addr_tw : '0;
  assign bus.oWR_EN     = wv_q[LAT-1];
  assign bus.oWR_ADDR_A = wa_q[LAT-1];
  assign bus.oWR_ADDR_B = wb_q[LAT-1];
endmodule

// File: tb/tb_ntt_butterfly_scheduler.sv
// tb/tb_ntt_butterfly_scheduler.sv - directed self-checking bench for ntt_butterfly_scheduler (LOGN=8, LAT=5)
module tb_ntt_butterfly_scheduler;
  localparam int LOGN = 8;
  localparam int LAT  = 5;
  localparam int N    = 256;
  localparam int H    = 128;
  localparam int PER  = H + LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ntt_butterfly_scheduler_if #(.LOGN(LOGN)) bus ();

  ntt_butterfly_scheduler #(.LOGN(LOGN), .LAT(LAT)) dut (
    .iSYS_CLK (clk),
    .iSYS_RST (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tw;
  } op_t;

  // Expected read issued in cycle c of a run (cycle 1 = first cycle after the start edge).
  function automatic op_t model(input logic [1:0] mode, input int c);
    op_t r;
    int s, k, len, g, j, a;
    r = '0;
    if (c < 1) return r;
    if (mode == 2'b10) begin
      if (c - 1 < N) begin
        r.v = 1'b1; r.a = 8'(c - 1); r.b = 8'(c - 1); r.tw = 8'(c - 1);
      end
      return r;
    end
    s = (c - 1) / PER;
    k = (c - 1) % PER;
    if (s >= LOGN || k >= H) return r;
    len = (mode == 2'b00) ? (N >> (s + 1)) : (1 << s);
    g = k / len;
    j = k % len;
    a = 2 * g * len + j;
    r.v  = 1'b1;
    r.a  = 8'(a);
    r.b  = 8'(a + len);
    r.tw = (mode == 2'b00) ? 8'((1 << s) + g) : 8'((N >> (s + 1)) + g);
    return r;
  endfunction

  function automatic logic [45:0] outs();
    return {bus.oBUSY, bus.oDONE, bus.oRD_EN, bus.oRD_ADDR_A, bus.oRD_ADDR_B, bus.oTW_ADDR,
            bus.oBUF_SEL, bus.oBUF_START, bus.oWR_EN, bus.oWR_ADDR_A, bus.oWR_ADDR_B};
  endfunction

  task automatic chk_rd(input string name, input logic [7:0] a, input logic [7:0] b, input logic [7:0] tw);
    checks++;
    if ({bus.oRD_EN, bus.oRD_ADDR_A, bus.oRD_ADDR_B, bus.oTW_ADDR} !== {1'b1, a, b, tw}) begin
      failures++;
      $display("FAIL %s got en=%b A=%0d B=%0d tw=%0d exp en=1 A=%0d B=%0d tw=%0d", name,
               bus.oRD_EN, bus.oRD_ADDR_A, bus.oRD_ADDR_B, bus.oTW_ADDR, a, b, tw);
    end
  endtask

  task automatic run_op(input logic [1:0] mode, input int dc, input int abort_at,
                        input int restart_at, input string name);
    int    errs, wrs, done_at, bad;
    op_t   r, w;
    string first;
    logic  exp_busy;
    errs = 0; wrs = 0; done_at = -1; first = "";
    @(negedge clk);
    bus.iSTART = 1'b1;
    bus.iMODE  = mode;
    @(posedge clk);
    #1 bus.iSTART = 1'b0;
    for (int c = 1; c <= dc + 3; c++) begin
      @(negedge clk);
      if (c == restart_at) begin
        bus.iSTART = 1'b1; bus.iMODE = 2'b10;
      end else if (c == restart_at + 1) begin
        bus.iSTART = 1'b0; bus.iMODE = mode;
      end
      r = model(mode, c);
      w = model(mode, c - LAT);
      exp_busy = (c <= dc);
      if (bus.oRD_EN !== r.v || (r.v && {bus.oRD_ADDR_A, bus.oRD_ADDR_B, bus.oTW_ADDR} !== {r.a, r.b, r.tw})) begin
        if (errs == 0) first = $sformatf("rd c=%0d got %b %0d/%0d/%0d exp %b %0d/%0d/%0d", c,
          bus.oRD_EN, bus.oRD_ADDR_A, bus.oRD_ADDR_B, bus.oTW_ADDR, r.v, r.a, r.b, r.tw);
        errs++;
      end
      if (bus.oWR_EN !== w.v || (w.v && {bus.oWR_ADDR_A, bus.oWR_ADDR_B} !== {w.a, w.b})) begin
        if (errs == 0) first = $sformatf("wr c=%0d got %b %0d/%0d exp %b %0d/%0d", c,
          bus.oWR_EN, bus.oWR_ADDR_A, bus.oWR_ADDR_B, w.v, w.a, w.b);
        errs++;
      end
      if (bus.oBUSY !== exp_busy || bus.oBUF_START !== exp_busy ||
          bus.oBUF_SEL !== (exp_busy && mode == 2'b01)) begin
        if (errs == 0) first = $sformatf("ctl c=%0d busy=%b start=%b sel=%b exp busy=%b", c,
          bus.oBUSY, bus.oBUF_START, bus.oBUF_SEL, exp_busy);
        errs++;
      end
      if (bus.oWR_EN === 1'b1) wrs++;
      if (bus.oDONE === 1'b1 && done_at < 0) done_at = c;
      if (mode == 2'b00 && c == 1)           chk_rd({name, "_s0_first"}, 8'd0, 8'd128, 8'd1);
      if (mode == 2'b00 && c == 1 + 7 * PER) chk_rd({name, "_s7_first"}, 8'd0, 8'd1, 8'd128);
      if (mode == 2'b00 && c == 1 + PER + 70) chk_rd({name, "_s1_k70"}, 8'd134, 8'd198, 8'd3);
      if (mode == 2'b01 && c == 1)           chk_rd({name, "_s0_first"}, 8'd0, 8'd1, 8'd128);
      if (mode == 2'b01 && c == 1 + 7 * PER) chk_rd({name, "_s7_first"}, 8'd0, 8'd128, 8'd1);
      if (mode == 2'b10 && c == 1)           chk_rd({name, "_k0"}, 8'd0, 8'd0, 8'd0);
      if (mode == 2'b10 && c == 256)         chk_rd({name, "_k255"}, 8'd255, 8'd255, 8'd255);
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 46'd0) begin
          failures++;
          $display("FAIL %s_async_reset_outputs got %h exp 0", name, outs());
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (bus.oWR_EN !== 1'b0 || bus.oBUSY !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL %s_post_reset_quiet got %0d active cycles exp 0", name, bad);
        end
        return;
      end
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL %s_sequence errs=%0d first: %s", name, errs, first);
    end
    checks++;
    if (done_at != dc) begin
      failures++;
      $display("FAIL %s_done_cycle got %0d exp %0d", name, done_at, dc);
    end
    checks++;
    if (wrs != ((mode == 2'b10) ? 256 : 1024)) begin
      failures++;
      $display("FAIL %s_write_count got %0d exp %0d", name, wrs, (mode == 2'b10) ? 256 : 1024);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (outs() !== 46'd0) begin
      failures++;
      $display("FAIL reset_outputs got %h exp 0", outs());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.oBUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy got %b exp 0", bus.oBUSY);
    end
  endtask

  task automatic test_ct();
    run_op(2'b00, 1065, 0, 0, "ct");
  endtask

  task automatic test_reset_mid_run();
    run_op(2'b00, 1065, 300, 0, "ct_abort");
    run_op(2'b00, 1065, 0, 0, "ct_after_reset");
  endtask

  task automatic test_gs_restart_ignored();
    run_op(2'b01, 1065, 0, 50, "gs");
  endtask

  task automatic test_pwm();
    run_op(2'b10, 262, 0, 0, "pwm");
  endtask

  task automatic test_reserved_mode();
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    bus.iSTART = 1'b1;
    bus.iMODE  = 2'b11;
    @(negedge clk);
    bus.iSTART = 1'b0;
    repeat (5) begin
      if (bus.oBUSY !== 1'b0 || bus.oRD_EN !== 1'b0) busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 0) begin
      failures++;
      $display("FAIL reserved_mode busy cycles got %0d exp 0", busy_cnt);
    end
  endtask

  initial begin
    bus.iSTART = 1'b0;
    bus.iMODE  = 2'b00;
`ifdef NTT_SCHED_STALL_EN
    bus.iSTALL = 1'b0;
`endif
    test_reset();
    test_ct();
    test_reset_mid_run();
    test_gs_restart_ignored();
    test_pwm();
    test_reserved_mode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ntt_butterfly_scheduler.md
NTT_BUTTERFLY_SCHEDULER -- requirements
Module: ntt_butterfly_scheduler

Interface
REQ-001 Parameter LOGN, default 8, log2 of polynomial length N = 2^LOGN.
REQ-002 Parameter LAT, default 5, butterfly unit latency in cycles, from operand read to result valid; LAT >= 1.
REQ-003 Port iSYS_CLK, input, 1, system clock; all state SHALL be updated on its rising edge.
REQ-004 Port iSYS_RST, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-005 Port iSTART, input, 1, start request; sampled only in IDLE.
REQ-006 Port iMODE, input, 2, operation: 00 CT forward NTT, 01 GS inverse NTT, 10 PWM, 11 reserved.
REQ-007 Port oBUSY, output, 1, high in any state other than IDLE.
REQ-008 Port oDONE, output, 1, one-cycle completion pulse.
REQ-009 Ports oRD_EN / oRD_ADDR_A / oRD_ADDR_B, output, 1 / LOGN / LOGN, operand read strobe and addresses.
REQ-010 Port oTW_ADDR, output, LOGN, twiddle-table address (CT: forward table; GS: inverse table; PWM: second-operand address).
REQ-011 Port oBUF_SEL, output, 1, butterfly mode select: 1 for GS, 0 otherwise.
REQ-012 Port oBUF_START, output, 1, butterfly enable; equals oBUSY.
REQ-013 Ports oWR_EN / oWR_ADDR_A / oWR_ADDR_B, output, 1 / LOGN / LOGN, result write strobe and addresses.

Function
REQ-014 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE -> ISSUE when iSTART=1 and iMODE!=11; iMODE latched at this edge; iMODE=11 SHALL be ignored (stay IDLE).
REQ-016 ISSUE: one operation per cycle, oRD_EN=1, counter k increments.
REQ-017 CT stage s (0..LOGN-1): len=N>>(s+1), g=k/len, j=k%len, k in 0..N/2-1; A=2*g*len+j; B=A+len; tw=(1<<s)+g.
REQ-018 GS stage s (0..LOGN-1): len=1<<s, with A, B and g computed as in REQ-017; tw=(N>>(s+1))+g.
REQ-019 PWM: single pass, k in 0..N-1; A=B=tw=k.
REQ-020 After the last k of a pass -> DRAIN for exactly LAT cycles, oRD_EN=0.
REQ-021 After DRAIN -> ISSUE for the next stage, or -> DONE if the final stage is complete.
REQ-022 DONE lasts one cycle with oDONE=1, then -> IDLE.
REQ-023 Write-back: a read issued at cycle t SHALL produce oWR_EN=1 with the same A/B addresses at cycle t+LAT, via a LAT-deep address/valid shift register.
REQ-024 The last write of a stage coincides with the final DRAIN cycle, and the next stage's first read follows one cycle later (no RAW hazard).
REQ-025 Latency from the iSTART sampling edge (cycle 0): CT/GS oDONE at cycle 1+LOGN*(N/2+LAT); PWM oDONE at cycle 1+N+LAT.
REQ-026 iSTART while oBUSY=1 SHALL be ignored, and the latched mode SHALL not change mid-operation.
REQ-027 Addresses SHALL never exceed N-1; counters wrap to 0 at stage boundaries.

Reset
REQ-028 Asserting iSYS_RST at any time, including mid-operation, SHALL immediately force IDLE.
REQ-029 On reset, all outputs SHALL be 0, the shift register SHALL be cleared, and no pending write SHALL be emitted after release.
REQ-030 After reset release, the first iSTART SHALL begin a fresh operation from stage 0, k=0.

Configuration
REQ-031 Macro NTT_SCHED_STALL_EN, when defined, SHALL add port iSTALL (input, 1).
REQ-032 With the macro, iSTALL=1 in ISSUE SHALL freeze k and s and force oRD_EN=0; in-flight entries continue shifting and writing.
REQ-033 Without the macro, iSTALL SHALL be absent and behaviour SHALL equal iSTALL tied to 0.

Verification (LOGN=8, LAT=5)
REQ-034 iMODE=00, iSTART pulse -> first read A=0, B=128, tw=1; stage 7 first read A=0, B=1, tw=128; oDONE at cycle 1065; exactly 1024 writes.
REQ-035 iMODE=01 -> stage 0 first read A=0, B=1, tw=128, oBUF_SEL=1; stage 7 first read A=0, B=128, tw=1; oDONE at cycle 1065.
REQ-036 iMODE=10 -> reads k=0..255 with A=B=tw=k, writes at cycles 6..261, oDONE at cycle 262.
REQ-037 iSYS_RST asserted at cycle 300 of a CT run -> all outputs 0 immediately; no writes after release; a new CT run completes normally.
REQ-038 iMODE=11 with iSTART -> oBUSY remains 0; a second iSTART during a busy run -> no effect on address sequence or oDONE timing.
REQ-039 With NTT_SCHED_STALL_EN, iSTALL=1 for 10 cycles mid-stage -> read sequence resumes without skip or repeat, and oDONE is delayed by exactly 10 cycles.
